gray_cnt_monitor: RTL
=====================

# gray_cnt_monitor

Checker stage directly downstream of the Gray counter. Registers the Gray-coded count, decodes it to binary and verifies every step against the expected sequence: binary advances by INCREMENT modulo SIZE, one step per clock. Reports the decoded value, wrap events, step errors and a saturating error count. Sits between the counter and any consumer that needs a trusted binary count.

## Interface
- SIZE, 10: count modulus; legal binary values are 0..SIZE-1.
- BIT_SIZE, 4: width of the Gray and binary count; requires 2**BIT_SIZE >= SIZE.
- INCREMENT, 1: expected binary step per clock; requires 0 < INCREMENT < SIZE.
- ALLOW_HOLD, 0: 1 = a repeated value is legal (no step, no error).
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- gray_i  in  BIT_SIZE  Gray-coded count from upstream counter.
- bin_o  out  BIT_SIZE  decoded binary of the sample being checked.
- bin_valid_o  out  1  bin_o holds a decoded sample.
- locked_o  out  1  checker is in LOCKED state.
- wrap_o  out  1  one-cycle pulse: correct step that crossed SIZE.
- err_o  out  1  one-cycle pulse: step error or out-of-range value.
- err_cnt_o  out  8  error count, saturates at 255.

## Operation
- Stage 1: gray_q <= gray_i, v1 <= 1. Stage 2: bin_o <= gray2bin(gray_q), bin_valid_o <= v1. The check result is registered with stage 2, so all outputs are aligned.
- Expected next value: exp = (ref + INCREMENT) mod SIZE. Compute the sum at BIT_SIZE+1 bits. Subtract SIZE when sum >= SIZE.
- A decoded value b is out of range when b >= SIZE.
- The checker has two states: ACQ and LOCKED.
  - ACQ, no reference: an in-range b becomes the reference. An out-of-range b gives err_o.
  - ACQ, with reference: if b == exp, move to LOCKED and set ref = b. Otherwise set ref = b with no error. Out-of-range gives err_o and clears the reference.
  - LOCKED: if b == exp, set ref = b, and pulse wrap_o when ref + INCREMENT >= SIZE. If b == ref and ALLOW_HOLD = 1, no action. Any other b, including out of range, gives err_o, moves to ACQ and sets ref = b (no reference if b is out of range).
- Every err_o pulse increments err_cnt_o, which holds at 255.
- Reset clears all of the following to 0 on the edge where rst_i is sampled high: gray_q, v1, bin_o, bin_valid_o, locked_o, wrap_o, err_o, err_cnt_o, state (ACQ) and reference valid.
- Reset mid-operation aborts and restarts acquisition. No error is reported for the discontinuity.

## Timing
- Latency from gray_i to bin_o, err_o and wrap_o is 2 clocks.
- The first gray_i sampled after reset appears on bin_o with bin_valid_o = 1 at the second edge after sampling.
- locked_o rises in the same cycle bin_o shows the second consecutive correct value. In a clean run that is the second valid sample.
- err_o and wrap_o are exactly one cycle wide per offending or wrapping sample. They are never asserted together.
- In the cycle err_o is high, locked_o is already 0.
- Back-to-back errors each pulse and each count.
- wrap_o fires on a correct wrap step even when the Gray transition changed more than one bit (non-power-of-2 SIZE).

## Structure
- Package gray_pkg holds:
  - function gray2bin(parameterised width), an XOR prefix from the MSB;
  - enum state_t {ACQ, LOCKED};
  - localparam ERR_CNT_W = 8.
- Sub-module gray_decode_stage covers stage 1, stage 2 and the valid bits, using gray2bin. The top level holds the checker FSM, the exp arithmetic and the error counter.

## Test plan
Defaults are SIZE = 10, BIT_SIZE = 4, INCREMENT = 1. Gray codes for 0..9 are 0, 1, 3, 2, 6, 7, 5, 4, 12, 13.
- Clean run: reset 2 cycles, then Gray 0, 1, 3, …, 13, 0, 1 → bin_o = 0..9, 0, 1; locked_o = 1 from bin_o = 1; wrap_o pulses only with bin_o = 0 after 9; err_o never.
- Skip while locked: …, Gray 2 (3), then 7 (5), 5 (6), 4 (7) → err_o with bin_o = 5; err_cnt_o = 1; locked_o = 0 at 5; locked_o = 1 at bin_o = 6.
- Out of range: Gray 15 (binary 10) while locked → err_o, locked_o = 0, no reference; next in-range value only seeds the reference; relock one sample later.
- Hold: repeat Gray 3 twice → ALLOW_HOLD = 0 gives err_o; ALLOW_HOLD = 1 gives no error and locked_o stays 1.
- INCREMENT = 3: binary 0, 3, 6, 9, 2, 5 → wrap_o only with bin_o = 2; no errors.
- Reset and saturation: force 300 errors → err_cnt_o = 255. Then one-cycle rst_i mid-stream → the next edge shows all outputs 0, and reacquisition completes as in the clean run.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types, constants and the Gray-to-binary helper for the Gray count monitor.
package gray_pkg;

   localparam int ERR_CNT_W  = 8;
   localparam int GRAY_MAX_W = 32;

   typedef enum logic {
      ACQ    = 1'b0,
      LOCKED = 1'b1
   } state_t;

   // XOR prefix from the MSB; narrower codes are zero-extended by the caller,
   // which leaves the decoded low bits unchanged for any width up to GRAY_MAX_W.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
      logic [GRAY_MAX_W-1:0] bin;
      bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_decode_stage.sv
// Two-stage Gray capture and decode; exposes the stage-1 decode so the checker
// can register its verdict alongside the stage-2 binary output.
module gray_decode_stage
   import gray_pkg::*;
#(
   parameter int BIT_SIZE = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [BIT_SIZE-1:0] gray_i,
   output logic [BIT_SIZE-1:0] dec_bin_o,
   output logic                dec_valid_o,
   output logic [BIT_SIZE-1:0] bin_o,
   output logic                bin_valid_o
);

   logic [BIT_SIZE-1:0] gray_q;
   logic                v1;

   assign dec_bin_o   = BIT_SIZE'(gray2bin(GRAY_MAX_W'(gray_q)));
   assign dec_valid_o = v1;

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gray_q      <= '0;
         v1          <= 1'b0;
         bin_o       <= '0;
         bin_valid_o <= 1'b0;
      end else begin
         gray_q      <= gray_i;
         v1          <= 1'b1;
         bin_o       <= dec_bin_o;
         bin_valid_o <= v1;
      end
   end

endmodule

// File: rtl/gray_cnt_monitor.sv
// Gray count checker: decodes the upstream count and verifies each step against
// (ref + INCREMENT) mod SIZE, reporting wraps, step errors and a saturating error count.
module gray_cnt_monitor
   import gray_pkg::*;
#(
   parameter int SIZE       = 10,
   parameter int BIT_SIZE   = 4,
   parameter int INCREMENT  = 1,
   parameter int ALLOW_HOLD = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [BIT_SIZE-1:0]  gray_i,
   output logic [BIT_SIZE-1:0]  bin_o,
   output logic                 bin_valid_o,
   output logic                 locked_o,
   output logic                 wrap_o,
   output logic                 err_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o
);

   localparam int SUM_W = BIT_SIZE + 1;

   logic [BIT_SIZE-1:0]  dec_bin;
   logic                 dec_valid;

   state_t               state_q, state_d;
   logic [BIT_SIZE-1:0]  ref_q, ref_d;
   logic                 ref_valid_q, ref_valid_d;
   logic                 err_d, wrap_d;
   logic                 err_q, wrap_q;
   logic [ERR_CNT_W-1:0] err_cnt_q;

   logic [SUM_W-1:0]     sum;
   logic [BIT_SIZE-1:0]  exp_bin;
   logic                 wrap_step, out_of_range, is_step, is_hold;

   gray_decode_stage #(
      .BIT_SIZE(BIT_SIZE)
   ) u_decode (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .gray_i     (gray_i),
      .dec_bin_o  (dec_bin),
      .dec_valid_o(dec_valid),
      .bin_o      (bin_o),
      .bin_valid_o(bin_valid_o)
   );

   // One extra bit so ref + INCREMENT cannot overflow before the modulo fold.
   assign sum          = {1'b0, ref_q} + SUM_W'(INCREMENT);
   assign wrap_step    = (sum >= SUM_W'(SIZE));
   assign exp_bin      = wrap_step ? BIT_SIZE'(sum - SUM_W'(SIZE)) : BIT_SIZE'(sum);
   assign out_of_range = ({1'b0, dec_bin} >= SUM_W'(SIZE));
   assign is_step      = (dec_bin == exp_bin);
   assign is_hold      = (ALLOW_HOLD != 0) && (dec_bin == ref_q);

   // NOTE: every variable gets a default first so no path infers a latch.
   always_comb begin
      state_d     = state_q;
      ref_d       = ref_q;
      ref_valid_d = ref_valid_q;
      err_d       = 1'b0;
      wrap_d      = 1'b0;
      if (dec_valid) begin
         if (out_of_range) begin
            err_d       = 1'b1;
            state_d     = ACQ;
            ref_valid_d = 1'b0;
         end else begin
            unique case (state_q)
               ACQ: begin
                  if (ref_valid_q && is_step) state_d = LOCKED;
                  ref_d       = dec_bin;
                  ref_valid_d = 1'b1;
               end
               LOCKED: begin
                  if (is_step) begin
                     ref_d  = dec_bin;
                     wrap_d = wrap_step;
                  end else if (!is_hold) begin
                     err_d   = 1'b1;
                     state_d = ACQ;
                     ref_d   = dec_bin;
                  end
               end
               default: state_d = ACQ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ACQ;
         ref_q       <= '0;
         ref_valid_q <= 1'b0;
         err_q       <= 1'b0;
         wrap_q      <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         ref_q       <= ref_d;
         ref_valid_q <= ref_valid_d;
         err_q       <= err_d;
         wrap_q      <= wrap_d;
         if (err_d && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
   end

   assign locked_o  = (state_q == LOCKED);
   assign wrap_o    = wrap_q;
   assign err_o     = err_q;
   assign err_cnt_o = err_cnt_q;

endmodule
